// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, signed or unsigned.
// An accepted start latches the operand magnitudes. The CALC state then runs
// WIDTH restoring steps. FIX applies the result signs and the divide-by-zero
// values. DONE presents the results with a one-cycle done pulse.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             signedOp,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divByZero,
    output logic             zeroFlag,
    output logic             signFlag
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] quo_q, quo_d;           // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] rem_q, rem_d;           // partial remainder
    logic [WIDTH-1:0] dvs_q, dvs_d;           // divisor magnitude
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_pend_q, dbz_pend_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;

    logic             dividend_neg, divisor_neg;
    logic [WIDTH-1:0] dividend_mag, divisor_mag;
    logic [WIDTH:0]   shifted, diff;

    assign dividend_neg = signedOp & dividend[WIDTH-1];
    assign divisor_neg  = signedOp & divisor[WIDTH-1];
    assign dividend_mag = dividend_neg ? -dividend : dividend;
    assign divisor_mag  = divisor_neg  ? -divisor  : divisor;

    // The partial remainder is always below the divisor. After the left shift it
    // therefore fits in WIDTH+1 bits. The top bit of diff is the borrow.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_q};

    assign busy      = (state_q == CALC) || (state_q == FIX);
    assign done      = (state_q == DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign divByZero = div_by_zero_q;
    assign zeroFlag  = (quotient_q == '0);
    assign signFlag  = quotient_q[WIDTH-1];

    // Next-state and datapath logic for the IDLE/CALC/FIX/DONE sequence.
    always_comb begin
        // NOTE: every signal gets a hold default first, so no path can infer a latch.
        state_d       = state_q;
        count_d       = count_q;
        quo_d         = quo_q;
        rem_d         = rem_q;
        dvs_d         = dvs_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        dbz_pend_d    = dbz_pend_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    div_by_zero_d = 1'b0;
                    count_d       = CW'(WIDTH - 1);
                    if (divisor == '0) begin
                        // Preload the divide-by-zero results so FIX just passes them through.
                        quo_d      = '1;
                        rem_d      = dividend;
                        dvs_d      = '0;
                        neg_quo_d  = 1'b0;
                        neg_rem_d  = 1'b0;
                        dbz_pend_d = 1'b1;
                        state_d    = FIX;
                    end else begin
                        quo_d      = dividend_mag;
                        rem_d      = '0;
                        dvs_d      = divisor_mag;
                        neg_quo_d  = dividend_neg ^ divisor_neg;
                        neg_rem_d  = dividend_neg;
                        dbz_pend_d = 1'b0;
                        state_d    = CALC;
                    end
                end
            end
            CALC: begin
                quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
                rem_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                if (count_q == '0) begin
                    state_d = FIX;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            FIX: begin
                quotient_d    = neg_quo_q ? -quo_q : quo_q;
                remainder_d   = neg_rem_q ? -rem_q : rem_q;
                div_by_zero_d = dbz_pend_q;
                state_d       = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register. Reset abandons any division that is in progress.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q       <= IDLE;
            count_q       <= '0;
            quo_q         <= '0;
            rem_q         <= '0;
            dvs_q         <= '0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            dbz_pend_q    <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make all flops update from pre-edge values.
            state_q       <= state_d;
            count_q       <= count_d;
            quo_q         <= quo_d;
            rem_q         <= rem_d;
            dvs_q         <= dvs_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            dbz_pend_q    <= dbz_pend_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider. The expected results come from plain
// arithmetic. The expected timing comes from the done/busy cycle counts after
// each accepted start.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rstN;
    logic         start;
    logic [W-1:0] dividend, divisor;
    logic         signedOp;
    logic         busy, done, divByZero, zeroFlag, signFlag;
    logic [W-1:0] quotient, remainder;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rstN(rstN), .start(start), .dividend(dividend), .divisor(divisor),
        .signedOp(signedOp), .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .divByZero(divByZero), .zeroFlag(zeroFlag), .signFlag(signFlag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference behaviour: truncating division, with the remainder taking the dividend's sign.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        longint sa, sb, qq, rr;
        dz = 1'b0;
        if (b == '0) begin
            q = '1; r = a; dz = 1'b1;
        end else if (!s) begin
            q = a / b; r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            qq = sa / sb;
            rr = sa % sb;
            q  = qq[W-1:0];
            r  = rr[W-1:0];
        end
    endfunction

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           acc;
        int           lat;
    } exp_t;

    exp_t expq[$];
    bit   mon_en = 1'b0;

    // Compare process: checks busy on every cycle and checks the full result on each done.
    always @(negedge clk) begin : monitor
        int   d;
        bit   eb;
        exp_t e;
        if (mon_en && rstN) begin
            eb = 1'b0;
            if (expq.size() > 0) begin
                d  = cyc - expq[0].acc;
                eb = (d >= 1) && (d < expq[0].lat);
            end
            check("busy", busy, eb);
            if (done) begin
                if (expq.size() == 0) begin
                    check("spurious_done", done, 0);
                end else begin
                    e = expq.pop_front();
                    check("latency", cyc - e.acc, e.lat);
                    check("quotient", quotient, e.q);
                    check("remainder", remainder, e.r);
                    check("divByZero", divByZero, e.dz);
                    check("zeroFlag", zeroFlag, e.q == '0);
                    check("signFlag", signFlag, e.q[W-1]);
                end
            end else if (expq.size() > 0 && (cyc - expq[0].acc) >= expq[0].lat) begin
                check("done_missing", done, 1);
                void'(expq.pop_front());
            end
        end
    end

    // Called just after a negedge. This drives one accepted start and queues its expectation.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        #1;
        dividend = a; divisor = b; signedOp = s; start = 1'b1;
        model(a, b, s, e.q, e.r, e.dz);
        e.acc = cyc;
        e.lat = (b == '0) ? 2 : W + 2;
        expq.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) check("done_timeout", done, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_dbz"}, divByZero, 0);
        check({tag, "_quotient"}, quotient, 0);
        check({tag, "_remainder"}, remainder, 0);
        check({tag, "_zeroFlag"}, zeroFlag, 1);
        check({tag, "_signFlag"}, signFlag, 0);
    endtask

    initial begin : stim
        logic [W-1:0] mq, mr, a, b;
        logic         mdz, s;
        int           ndone;

        rstN = 1'b0; start = 1'b0; dividend = '0; divisor = '0; signedOp = 1'b0;
        #2 check_reset_outputs("reset");

        // Pin the reference model with hand-computed values.
        model(32'd100, 32'd7, 1'b0, mq, mr, mdz);
        check("model_100_7_q", mq, 32'd14);
        check("model_100_7_r", mr, 32'd2);
        model(32'hFFFF_FFF9, 32'd2, 1'b1, mq, mr, mdz);
        check("model_neg7_2_q", mq, 32'hFFFF_FFFD);
        check("model_neg7_2_r", mr, 32'hFFFF_FFFF);
        model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mq, mr, mdz);
        check("model_ovf_q", mq, 32'h8000_0000);
        check("model_ovf_r", mr, 32'd0);

        repeat (2) @(negedge clk);
        #1 rstN = 1'b1;
        mon_en = 1'b1;

        // Directed cases with literal expectations.
        @(negedge clk); issue(32'd100, 32'd7, 1'b0); wait_done();
        check("d_100_7_q", quotient, 32'd14);
        check("d_100_7_r", remainder, 32'd2);

        @(negedge clk); issue(32'hFFFF_FFF9, 32'd2, 1'b1); wait_done();
        check("d_neg7_q", quotient, 32'hFFFF_FFFD);
        check("d_neg7_r", remainder, 32'hFFFF_FFFF);
        check("d_neg7_sign", signFlag, 1);

        for (int m = 0; m < 2; m++) begin
            @(negedge clk); issue(32'd5, 32'd0, m[0]); wait_done();
            check("d_dbz_q", quotient, 32'hFFFF_FFFF);
            check("d_dbz_r", remainder, 32'd5);
            check("d_dbz_flag", divByZero, 1);
        end

        @(negedge clk); issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_done();
        check("d_ovf_q", quotient, 32'h8000_0000);
        check("d_ovf_r", remainder, 32'd0);
        check("d_ovf_dbz", divByZero, 0);

        @(negedge clk); issue(32'd0, 32'd9, 1'b0); wait_done();
        check("d_zero_q", quotient, 32'd0);
        check("d_zero_flag", zeroFlag, 1);

        // A start while busy is ignored. A start during done is accepted back-to-back.
        @(negedge clk); issue(32'd100, 32'd7, 1'b0);
        repeat (4) @(negedge clk);
        #1 dividend = 32'd50; divisor = 32'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        check("d_ignored_q", quotient, 32'd14);
        check("d_ignored_r", remainder, 32'd2);
        issue(32'd20, 32'd3, 1'b0); wait_done();
        check("d_b2b_q", quotient, 32'd6);
        check("d_b2b_r", remainder, 32'd2);

        // Reset in the middle of a division.
        @(negedge clk); issue(32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        #1 rstN = 1'b0;
        expq.delete();
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        #1 rstN = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("no_done_after_reset", ndone, 0);

        // Randomised operands, with occasional back-to-back starts.
        for (int n = 0; n < 150; n++) begin
            s = $urandom_range(0, 1);
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = $urandom_range(1, 15);
                2:       b = -$urandom_range(1, 15);
                3:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0:       a = 32'h8000_0000;
                1:       a = $urandom_range(0, 100);
                default: a = $urandom;
            endcase
            if ($urandom_range(0, 3) != 0) @(negedge clk);
            issue(a, b, s);
            wait_done();
        end

        @(negedge clk);
        check("queue_drained", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; only 32 is required to be supported.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rstN  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request; sampled only while busy=0.
REQ-005 Port: dividend  input  WIDTH  numerator; captured on accepted start.
REQ-006 Port: divisor  input  WIDTH  denominator; captured on accepted start.
REQ-007 Port: signedOp  input  1  1 = two's-complement divide, 0 = unsigned; captured on accepted start.
REQ-008 Port: busy  output  1  high from the cycle after acceptance until done.
REQ-009 Port: done  output  1  one-cycle pulse; results valid in that cycle.
REQ-010 Port: quotient  output  WIDTH  result quotient, held until the next accepted start.
REQ-011 Port: remainder  output  WIDTH  result remainder, held until the next accepted start.
REQ-012 Port: divByZero  output  1  set with done when captured divisor = 0.
REQ-013 Port: zeroFlag  output  1  quotient == 0, same hold rule as quotient.
REQ-014 Port: signFlag  output  1  quotient[WIDTH-1].

Function
REQ-015 States SHALL be IDLE, CALC, FIX, DONE; encoding free.
REQ-016 Accept: start=1 in IDLE or DONE SHALL latch operands and signedOp (cycle 0), then move to CALC, or to FIX if divisor=0.
REQ-017 start while in CALC or FIX SHALL be ignored; no operand recapture, no state change.
REQ-018 CALC SHALL run restoring division on operand magnitudes, one quotient bit per cycle, MSB first, for exactly WIDTH cycles, then move to FIX.
REQ-019 Magnitude: when signedOp=1, a negative operand SHALL be negated before CALC; when signedOp=0, operands SHALL be used as-is.
REQ-020 FIX (1 cycle) SHALL apply signs: quotient negated iff signedOp and operand signs differ; remainder negated iff signedOp and dividend negative (truncate toward zero).
REQ-021 DONE SHALL last 1 cycle with done=1, outputs updated, busy=0; the next state is IDLE unless start=1.
REQ-022 Latency: done SHALL be high in cycle WIDTH+2 after acceptance (34 for WIDTH=32); divide-by-zero: in cycle 2.
REQ-023 Divide by zero SHALL give quotient = all ones, remainder = dividend, divByZero=1, in both modes.
REQ-024 Signed overflow (0x80000000 / 0xFFFFFFFF, signedOp=1) SHALL give quotient 0x80000000, remainder 0, divByZero=0.
REQ-025 divByZero SHALL clear on the next accepted start.
REQ-026 Invariant: for nonzero divisor, quotient*divisor + remainder = dividend (mod 2^WIDTH), and |remainder| < |divisor|.
REQ-027 busy SHALL be 1 exactly in CALC and FIX.

Reset
REQ-028 rstN low SHALL, without a clock, force IDLE; busy, done, divByZero = 0; quotient, remainder = 0; zeroFlag=1; signFlag=0.
REQ-029 Reset mid-operation SHALL abandon the division; no done pulse SHALL follow release.
REQ-030 The first accepted start SHALL be no earlier than the first rising edge after rstN deasserts.

Verification
REQ-031 Unsigned 100/7 -> quotient 14, remainder 2, done at cycle 34, busy high cycles 1-33.
REQ-032 Signed 0xFFFFFFF9 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF, signFlag=1.
REQ-033 5/0 (either mode) -> quotient 0xFFFFFFFF, remainder 5, divByZero=1, done at cycle 2.
REQ-034 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned 0/9 -> quotient 0, zeroFlag=1.
REQ-035 Start 100/7, pulse start with 50/5 at cycle 5 -> ignored, result 14 r 2 at cycle 34; a new start at cycle 34 is accepted back-to-back.
REQ-036 Start 100/7, rstN low at cycle 10 -> all outputs at reset values immediately; no done within 40 cycles after release.
